// File: rtl/main_memory.sv
// main_memory: line-oriented backing store for a cache controller.
// Each request moves one 256-bit line. Read data or a write commit completes
// a fixed LATENCY cycles after the request is accepted.
// Optional feature macro: MAIN_MEMORY_ALIGN_CHECK_EN adds err_o. With it,
// misaligned requests (addr_i[4:0] != 0) flag an error, drop writes and leave
// data_o untouched on reads.
//
// Handshake: the controller raises cs_i with addr_i/we_i/data_i valid. The
// memory is "ready" only while idle (fsm_state == IDLE). The request is taken
// on the first rising edge where the memory is idle and rst is low, and its
// inputs are captured at that edge. Input activity while busy or acking is
// ignored. ack_o is a one-cycle completion pulse. For a read, data_o is valid
// from that cycle until the next read completes.
module main_memory #(
    parameter int LATENCY   = 10,
    parameter int MEM_LINES = 512
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  addr_i,
    input  logic         cs_i,
    input  logic         we_i,
    input  logic [255:0] data_i,
    output logic [255:0] data_o,
    output logic         ack_o,
`ifdef MAIN_MEMORY_ALIGN_CHECK_EN
    output logic         err_o,
`endif
    output logic [1:0]   fsm_state
);

    localparam int         IDX_W    = $clog2(MEM_LINES);
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             accept;

    logic [IDX_W-1:0] line_q;
    logic             we_q;
    logic [255:0]     wdata_q;
    logic             misalign_q;

    logic [IDX_W-1:0] addr_line;
    logic             misalign;
    logic             unused_addr_bits;

    // The request being served. When LATENCY is 1, the fetch happens on the
    // accept edge, so the live inputs must be used instead of the latches.
    logic [IDX_W-1:0] req_line;
    logic             req_we;
    logic             req_mis;

    logic [255:0]     mem [MEM_LINES];

    assign addr_line = addr_i[4+IDX_W:5];

`ifdef MAIN_MEMORY_ALIGN_CHECK_EN
    assign misalign         = |addr_i[4:0];
    assign unused_addr_bits = ^addr_i[31:5+IDX_W];
`else
    assign misalign         = 1'b0;
    assign unused_addr_bits = ^{addr_i[31:5+IDX_W], addr_i[4:0]};
`endif

    assign req_line = accept ? addr_line : line_q;
    assign req_we   = accept ? we_i      : we_q;
    assign req_mis  = accept ? misalign  : misalign_q;

    // FSM next state, latency counter and request acceptance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_i) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? ACK : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers. Reset aborts any request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request so later input changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            line_q     <= addr_line;
            we_q       <= we_i;
            wdata_q    <= data_i;
            misalign_q <= misalign;
        end
    end

    // Write-back commits on the edge that ends the ACK cycle. The array is
    // never cleared.
    always_ff @(posedge clk) begin
        if (!rst && state_q == ACK && we_q && !misalign_q) begin
            mem[line_q] <= wdata_q;
        end
    end

    // Read data is loaded on the edge entering ACK and held until the next
    // read completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o <= '0;
        end else if (state_d == ACK && state_q != ACK && !req_we && !req_mis) begin
            data_o <= mem[req_line];
        end
    end

    assign ack_o     = (state_q == ACK);
    assign fsm_state = state_q;

`ifdef MAIN_MEMORY_ALIGN_CHECK_EN
    assign err_o = ack_o && misalign_q;
`endif

endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: randomized and directed bench for main_memory.
// A timing/contents reference model runs alongside the main DUT. A second
// instance with LATENCY=1 covers the single-cycle path.
// Optional feature macro: MAIN_MEMORY_ALIGN_CHECK_EN (err_o checks).
module tb_main_memory;

    localparam int LAT   = 10;
    localparam int LINES = 512;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT (LATENCY=10) ----------------
    logic [31:0]  addr  = '0;
    logic         cs    = 1'b0;
    logic         we    = 1'b0;
    logic [255:0] wdata = '0;
    logic [255:0] rdata;
    logic         ack;
    logic         err_w;
    logic [1:0]   st;

    main_memory #(.LATENCY(LAT), .MEM_LINES(LINES)) dut (
        .clk(clk), .rst(rst), .addr_i(addr), .cs_i(cs), .we_i(we),
        .data_i(wdata), .data_o(rdata), .ack_o(ack),
`ifdef MAIN_MEMORY_ALIGN_CHECK_EN
        .err_o(err_w),
`endif
        .fsm_state(st)
    );

    // ---------------- DUT (LATENCY=1) ----------------
    logic [31:0]  addr1  = '0;
    logic         cs1    = 1'b0;
    logic         we1    = 1'b0;
    logic [255:0] wdata1 = '0;
    logic [255:0] rdata1;
    logic         ack1;
    logic         err1_w;
    logic [1:0]   st1;

    main_memory #(.LATENCY(1), .MEM_LINES(16)) dut1 (
        .clk(clk), .rst(rst), .addr_i(addr1), .cs_i(cs1), .we_i(we1),
        .data_i(wdata1), .data_o(rdata1), .ack_o(ack1),
`ifdef MAIN_MEMORY_ALIGN_CHECK_EN
        .err_o(err1_w),
`endif
        .fsm_state(st1)
    );

`ifndef MAIN_MEMORY_ALIGN_CHECK_EN
    assign err_w  = 1'b0;
    assign err1_w = 1'b0;
`endif

    // ---------------- scoreboard counters ----------------
    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // ---------------- reference model ----------------
    // Request accepted at edge a (idle, no reset, cs high).
    // ack is visible in the cycle after edge a+LAT-1.
    // Write commits at edge a+LAT.
    // Next request can be accepted at edge a+LAT+1.
    int           n = 0;
    bit           busy = 1'b0;
    int           acc_n = 0;
    bit           m_we, m_mis;
    int           m_line;
    logic [255:0] m_data;
    logic [255:0] mdl_mem [LINES];
    bit           exp_ack = 1'b0;
    bit           exp_err = 1'b0;
    logic [255:0] exp_data = '0;

    always @(posedge clk) begin
        n = n + 1;
        if (rst) begin
            busy     = 1'b0;
            exp_ack  = 1'b0;
            exp_err  = 1'b0;
            exp_data = '0;
        end else begin
            if (busy && n == acc_n + LAT) begin
                if (m_we && !m_mis) mdl_mem[m_line] = m_data;
                busy = 1'b0;
            end else if (!busy && cs) begin
                busy   = 1'b1;
                acc_n  = n;
                m_we   = we;
                m_line = int'((addr >> 5) % 32'(LINES));
                m_data = wdata;
`ifdef MAIN_MEMORY_ALIGN_CHECK_EN
                m_mis  = (addr % 32'd32) != 32'd0;
`else
                m_mis  = 1'b0;
`endif
            end
            exp_ack = busy && (n == acc_n + LAT - 1);
            exp_err = exp_ack && m_mis;
            if (exp_ack && !m_we && !m_mis) exp_data = mdl_mem[m_line];
        end
    end

    // Per-cycle compare of the main DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ack_o", {255'd0, ack}, {255'd0, exp_ack});
            check("err_o", {255'd0, err_w}, {255'd0, exp_err});
            check("data_o", rdata, exp_data);
        end
    end

    // ---------------- driver ----------------
    // Issue one request, scramble the inputs while it is in flight, and
    // report the latency plus the data and err values seen in the ack cycle.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [255:0] d,
                          output int lat, output logic [255:0] rd, output logic e);
        int c0;
        lat = -1;
        rd  = '0;
        e   = 1'b0;
        @(negedge clk);
        cs = 1'b1; we = w; addr = a; wdata = d; c0 = n;
        for (int k = 0; k < 300 && lat < 0; k++) begin
            @(negedge clk);
            cs    = 1'b0;
            we    = 1'($urandom_range(0, 1));
            addr  = $urandom();
            wdata = rand256();
            if (ack) begin
                lat = n - c0;
                rd  = rdata;
                e   = err_w;
            end
        end
    endtask

    int           lat;
    logic [255:0] rd;
    logic         e;
    int           acks[$];
    int           c0;
    int           ack_cnt;

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_ack", {255'd0, ack}, 256'd0);
        check("reset_data", rdata, 256'd0);

        // Fill lines 0..31 so every later read has known contents.
        for (int i = 0; i < 32; i++) begin
            do_req(1'b1, 32'(i * 32), rand256(), lat, rd, e);
            check("init_wr_lat", 256'(lat), 256'(LAT));
        end

        // Write then read 0x40 with the A5 pattern.
        do_req(1'b1, 32'h0000_0040, {32{8'hA5}}, lat, rd, e);
        check("wr40_lat", 256'(lat), 256'd10);
        do_req(1'b0, 32'h0000_0040, '0, lat, rd, e);
        check("rd40_lat", 256'(lat), 256'd10);
        check("rd40_data", rd, {32{8'hA5}});

        // Index wrap: 0x4020 and 0x20 map to the same line.
        do_req(1'b1, 32'h0000_4020, {32{8'hC3}}, lat, rd, e);
        do_req(1'b0, 32'h0000_0020, '0, lat, rd, e);
        check("wrap_data", rd, {32{8'hC3}});

`ifdef MAIN_MEMORY_ALIGN_CHECK_EN
        do_req(1'b1, 32'h0000_0044, {32{8'h5A}}, lat, rd, e);
        check("mis_wr_err", {255'd0, e}, 256'd1);
        check("mis_wr_lat", 256'(lat), 256'd10);
        do_req(1'b0, 32'h0000_0040, '0, lat, rd, e);
        check("mis_rd_old", rd, {32{8'hA5}});
        check("mis_rd_err", {255'd0, e}, 256'd0);
`endif

        // Reset in the middle of a write to 0x80 aborts it.
        do_req(1'b1, 32'h0000_0080, {32{8'h3C}}, lat, rd, e);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = 32'h0000_0080; wdata = {32{8'h96}};
        ack_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            cs  = 1'b0;
            rst = (k == 5);
            if (ack) ack_cnt++;
        end
        check("abort_no_ack", 256'(ack_cnt), 256'd0);
        do_req(1'b0, 32'h0000_0080, '0, lat, rd, e);
        check("abort_old_data", rd, {32{8'h3C}});

        // cs held high for 30 cycles: acks at T+10 and T+21 only.
        @(negedge clk);
        cs = 1'b1; we = 1'b0; addr = 32'h0000_0040; c0 = n;
        acks.delete();
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (ack) acks.push_back(n - c0);
        end
        cs = 1'b0;
        check("hold_ack_count", 256'(acks.size()), 256'd2);
        if (acks.size() >= 2) begin
            check("hold_ack0", 256'(acks[0]), 256'd10);
            check("hold_ack1", 256'(acks[1]), 256'd21);
        end
        repeat (15) @(negedge clk);

        // LATENCY=1 instance: ack in the cycle right after the request.
        @(negedge clk);
        cs1 = 1'b1; we1 = 1'b1; addr1 = 32'h0000_0060; wdata1 = {32{8'h69}};
        @(negedge clk);
        check("l1_wr_ack", {255'd0, ack1}, 256'd1);
        cs1 = 1'b0; addr1 = $urandom(); wdata1 = rand256();
        @(negedge clk);
        check("l1_wr_ack_off", {255'd0, ack1}, 256'd0);
        cs1 = 1'b1; we1 = 1'b0; addr1 = 32'h0000_0060;
        @(negedge clk);
        check("l1_rd_ack", {255'd0, ack1}, 256'd1);
        check("l1_rd_data", rdata1, {32{8'h69}});
        cs1 = 1'b0;
        @(negedge clk);
        check("l1_rd_ack_off", {255'd0, ack1}, 256'd0);
        check("l1_rd_hold", rdata1, {32{8'h69}});

        // Random traffic on lines 0..31, occasional resets.
        for (int k = 0; k < 2500; k++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 299) == 0);
            cs    = ($urandom_range(0, 2) == 0);
            we    = 1'($urandom_range(0, 1));
            addr  = ($urandom() & 32'hFFFF_C000) | (32'($urandom_range(0, 31)) << 5)
                    | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : 32'd0);
            wdata = rand256();
        end
        @(negedge clk);
        rst = 1'b0;
        cs  = 1'b0;
        repeat (LAT + 5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/main_memory.md
MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 SHALL have parameter LATENCY, default 10, meaning the number of cycles from request acceptance to ack (legal range 1..255).
REQ-002 SHALL have parameter MEM_LINES, default 512, meaning the number of 256-bit lines stored (power of two).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port addr_i  input  32  byte address; line index = addr_i[4+log2(MEM_LINES):5].
REQ-006 SHALL have port cs_i  input  1  request strobe from the cache controller.
REQ-007 SHALL have port we_i  input  1  1 = line write-back, 0 = line fill (read).
REQ-008 SHALL have port data_i  input  256  write-back line data.
REQ-009 SHALL have port data_o  output  256  read line data.
REQ-010 SHALL have port ack_o  output  1  one-cycle completion pulse.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, ACK.
REQ-012 IDLE: cs_i=1 at edge T SHALL latch addr_i, we_i and data_i, load the counter with LATENCY-1, and enter BUSY (or ACK directly if LATENCY=1).
REQ-013 BUSY: SHALL decrement the counter each cycle and enter ACK when the counter reaches 0; ack_o SHALL be 1 exactly in cycle T+LATENCY.
REQ-014 ACK: ack_o=1 for exactly one cycle; next state SHALL be IDLE unconditionally.
REQ-015 Reads SHALL drive data_o with the addressed line in the ACK cycle and hold it until the next read ACK.
REQ-016 Writes SHALL commit the latched data_i to the latched line on the ACK cycle edge; data_o SHALL be unchanged by writes.
REQ-017 Changes on addr_i, we_i, data_i and cs_i during BUSY or ACK SHALL be ignored.
REQ-018 cs_i held high through ACK SHALL be accepted as a new request only in the following IDLE cycle; back-to-back requests therefore SHALL have a spacing of LATENCY+1 cycles.
REQ-019 addr_i bits above the index SHALL be ignored (address wraps modulo MEM_LINES lines); addr_i[4:0] SHALL be ignored (line-aligned access).
REQ-020 A read following a write to the same line SHALL return the written data.

Reset
REQ-021 rst=1 at an edge SHALL force IDLE, counter=0, ack_o=0, data_o=0.
REQ-022 rst during BUSY SHALL abort the request with no ack and no array write.
REQ-023 Array contents SHALL NOT be cleared by reset.
REQ-024 cs_i SHALL be ignored in any cycle where rst=1.

Configuration
REQ-025 Macro MAIN_MEMORY_ALIGN_CHECK_EN defined SHALL add output err_o (1 bit, reset 0), asserted with ack_o when the latched addr_i[4:0]!=0; such writes SHALL be suppressed and such reads SHALL leave data_o unchanged.
REQ-026 Without MAIN_MEMORY_ALIGN_CHECK_EN, err_o SHALL NOT exist and REQ-019 alignment masking SHALL apply.

Verification
REQ-027 Write line 0x0000_0040 with pattern 0xA5..A5, then read the same address -> ack_o exactly 10 cycles after each accept; read data_o=0xA5..A5.
REQ-028 LATENCY=1; read accepted at T -> ack_o=1 at T+1 only; data_o valid at T+1.
REQ-029 cs_i held high for 30 cycles -> ack_o pulses at T+10, T+21; no other ack.
REQ-030 rst asserted at T+5 of a write to 0x80 -> no ack; subsequent read of 0x80 returns the prior contents.
REQ-031 With MEM_LINES=512, write 0x0000_4020 then read 0x0000_0020 -> same line returned (wrap-around).
REQ-032 MAIN_MEMORY_ALIGN_CHECK_EN defined, write to 0x44 -> err_o=1 with ack_o; read of 0x40 returns the old data.
